// File: rtl/sm4_pkg.sv
// Shared SM4 definitions for the key-expansion block.
// Holds the FK constants, FSM encoding, round count, the S-box table,
// and the CK(i) generator.
package sm4_pkg;

  localparam int unsigned NUM_ROUNDS = 32;
  localparam int unsigned WORD_W     = 32;
  localparam int unsigned KEY_W      = 128;

  localparam logic [WORD_W-1:0] FK0 = 32'hA3B1BAC6;
  localparam logic [WORD_W-1:0] FK1 = 32'h56AA3350;
  localparam logic [WORD_W-1:0] FK2 = 32'h677D9197;
  localparam logic [WORD_W-1:0] FK3 = 32'hB27022DC;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  // S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sm4_sbox(input logic [7:0] x);
    logic [10:0] base;
    base = {~x, 3'b000};  // (255 - x) * 8
    return SBOX[base +: 8];
  endfunction

  // CK(i) byte j = ((4i + j) * 7) mod 256, MSB first.
  function automatic logic [WORD_W-1:0] sm4_ck(input logic [4:0] i);
    logic [WORD_W-1:0] ck;
    logic [7:0]        n;
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      n = {1'b0, i, 2'(j)};
      ck[8*(3-j) +: 8] = 8'(n * 8'd7);
    end
    return ck;
  endfunction

endpackage

// File: rtl/one_round_for_key_exp.sv
// One combinational SM4 key-expansion round.
// Ports: data_in (K0..K3, K0 in MSBs), ck_parameter_in (CK word),
//        count_round_in (round number, informational only),
//        result_out (shifted key state), rk_o (new round key).
module one_round_for_key_exp
  import sm4_pkg::*;
(
  input  logic [KEY_W-1:0]  data_in,
  input  logic [WORD_W-1:0] ck_parameter_in,
  input  logic [5:0]        count_round_in,
  output logic [KEY_W-1:0]  result_out,
  output logic [WORD_W-1:0] rk_o
);

  logic [WORD_W-1:0] k0, k1, k2, k3, x, b, t;
  logic              unused_round;

  assign unused_round = ^count_round_in;

  assign k0 = data_in[127:96];
  assign k1 = data_in[95:64];
  assign k2 = data_in[63:32];
  assign k3 = data_in[31:0];
  assign x  = k1 ^ k2 ^ k3 ^ ck_parameter_in;

  assign b = {sm4_sbox(x[31:24]), sm4_sbox(x[23:16]),
              sm4_sbox(x[15:8]),  sm4_sbox(x[7:0])};

  // Key-schedule linear transform: B ^ (B <<< 13) ^ (B <<< 23).
  assign t = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

  assign rk_o       = k0 ^ t;
  assign result_out = {k1, k2, k3, rk_o};

endmodule

// File: rtl/sm4_key_exp_ctrl.sv
// SM4 key-expansion sequencer: loads MK ^ FK, runs 32 rounds through
// one_round_for_key_exp (one per cycle), stores the round keys, and serves
// them through an indexed read port (reversed order when dec_i = 1).
// Ports: clk, rst (async active-high), start_i, mk_i, busy_o, done_o,
//        keys_valid_o, rd_idx_i, dec_i, rk_rd_o.
module sm4_key_exp_ctrl
  import sm4_pkg::*;
#(
  parameter bit REG_RD_OUT = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [KEY_W-1:0]  mk_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              keys_valid_o,
  input  logic [4:0]        rd_idx_i,
  input  logic              dec_i,
  output logic [WORD_W-1:0] rk_rd_o
);

  state_t            state;
  logic [4:0]        cnt;
  logic [KEY_W-1:0]  k_q;
  logic [WORD_W-1:0] rk_mem [NUM_ROUNDS];
  logic [KEY_W-1:0]  round_result;
  logic [WORD_W-1:0] round_rk;
  logic [4:0]        eff_idx;

  one_round_for_key_exp u_round (
    .data_in         (k_q),
    .ck_parameter_in (sm4_ck(cnt)),
    .count_round_in  ({1'b0, cnt}),
    .result_out      (round_result),
    .rk_o            (round_rk)
  );

  // Sequencer: IDLE waits for start, RUN writes one round key per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      k_q          <= '0;
      busy_o       <= 1'b0;
      done_o       <= 1'b0;
      keys_valid_o <= 1'b0;
      for (int i = 0; i < NUM_ROUNDS; i++) rk_mem[i] <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i) begin
            k_q          <= mk_i ^ {FK0, FK1, FK2, FK3};
            cnt          <= '0;
            state        <= RUN;
            busy_o       <= 1'b1;
            keys_valid_o <= 1'b0;
          end
        end
        RUN: begin
          rk_mem[cnt] <= round_rk;
          k_q         <= round_result;
          cnt         <= cnt + 5'd1;
          if (cnt == 5'(NUM_ROUNDS - 1)) begin
            state        <= IDLE;
            busy_o       <= 1'b0;
            done_o       <= 1'b1;
            keys_valid_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Decrypt consumes the schedule back to front.
  assign eff_idx = dec_i ? 5'(5'd31 - rd_idx_i) : rd_idx_i;

  generate
    if (REG_RD_OUT) begin : g_reg_rd
      logic [WORD_W-1:0] rk_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) rk_q <= '0;
        else     rk_q <= rk_mem[eff_idx];
      end
      assign rk_rd_o = rk_q;
    end else begin : g_comb_rd
      assign rk_rd_o = rk_mem[eff_idx];
    end
  endgenerate

endmodule

// File: tb/tb_sm4_key_exp_ctrl.sv
// Scoreboard bench for sm4_key_exp_ctrl: combinational-read and
// registered-read instances share the stimulus; expected key sets come
// from a word-level SM4 key-schedule model.
module tb_sm4_key_exp_ctrl;

  typedef logic [31:0][31:0] keys_t;
  typedef struct {
    int unsigned done_cyc;
    keys_t       keys;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [127:0] mk_i = '0;
  logic [4:0]   rd_idx_i = '0;
  logic         dec_i = 1'b0;
  logic         busy_c, done_c, kv_c, busy_r, done_r, kv_r;
  logic [31:0]  rk_c, rk_r;

  int unsigned  cyc = 0;
  int           checks = 0;
  int           errors = 0;
  exp_t         exp_q[$];
  exp_t         mon_e;
  keys_t        mdl_mem = '0;
  int unsigned  mdl_done = 0;
  logic         rd_pending = 1'b0;
  logic [31:0]  rd_exp = '0;
  logic         prev_valid = 1'b0;
  logic [31:0]  prev_exp = '0;
  int           run_n = 0;

  localparam logic [127:0] STD_MK = 128'h0123456789abcdeffedcba9876543210;

  sm4_key_exp_ctrl #(.REG_RD_OUT(1'b0)) dut_c (
    .clk(clk), .rst(rst), .start_i(start_i), .mk_i(mk_i),
    .busy_o(busy_c), .done_o(done_c), .keys_valid_o(kv_c),
    .rd_idx_i(rd_idx_i), .dec_i(dec_i), .rk_rd_o(rk_c));

  sm4_key_exp_ctrl #(.REG_RD_OUT(1'b1)) dut_r (
    .clk(clk), .rst(rst), .start_i(start_i), .mk_i(mk_i),
    .busy_o(busy_r), .done_o(done_r), .keys_valid_o(kv_r),
    .rd_idx_i(rd_idx_i), .dec_i(dec_i), .rk_rd_o(rk_r));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] ck_ref(input int i);
    logic [31:0] ck;
    ck = '0;
    for (int j = 0; j < 4; j++) ck = {ck[23:0], 8'(((4*i + j) * 7) % 256)};
    return ck;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] v, input int n);
    return (v << n) | (v >> (32 - n));
  endfunction

  function automatic logic [31:0] tprime(input logic [31:0] a);
    logic [31:0] b;
    for (int j = 0; j < 4; j++) b[8*j +: 8] = sm4_pkg::sm4_sbox(a[8*j +: 8]);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic keys_t expand(input logic [127:0] mk);
    logic [31:0] k [36];
    keys_t r;
    k[0] = mk[127:96] ^ 32'hA3B1BAC6;
    k[1] = mk[95:64]  ^ 32'h56AA3350;
    k[2] = mk[63:32]  ^ 32'h677D9197;
    k[3] = mk[31:0]   ^ 32'hB27022DC;
    for (int i = 0; i < 32; i++) begin
      k[i+4] = k[i] ^ tprime(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck_ref(i));
      r[i] = k[i+4];
    end
    return r;
  endfunction

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; the model decides whether it is honoured.
  task automatic issue_start(input logic [127:0] mk);
    exp_t e;
    start_i = 1'b1;
    mk_i    = mk;
    if (cyc >= mdl_done) begin
      e.done_cyc = cyc + 33;
      e.keys     = expand(mk);
      exp_q.push_back(e);
      mdl_done = cyc + 33;
    end
    step();
    start_i = 1'b0;
    mk_i    = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) step();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: got no done_o expected done at cycle %0d", exp_q[0].done_cyc);
      exp_q.delete();
    end
  endtask

  task automatic rd_const(input logic [4:0] idx, input logic dec, input logic [31:0] req);
    rd_idx_i   = idx;
    dec_i      = dec;
    rd_exp     = req;
    rd_pending = 1'b1;
    step();
  endtask

  task automatic rd_m(input logic [4:0] idx, input logic dec);
    rd_const(idx, dec, mdl_mem[dec ? 31 - int'(idx) : int'(idx)]);
  endtask

  task automatic rd_off();
    rd_pending = 1'b0;
    step();
    step();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done_c) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL done_unexpected: got done_o=1 expected 0 (cycle %0d)", cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("done_cycle", 128'(cyc), 128'(mon_e.done_cyc));
          chk("keys_valid_at_done", kv_c, 1'b1);
          chk("busy_at_done", busy_c, 1'b0);
          mdl_mem = mon_e.keys;
        end
      end
      if (busy_c) begin
        chk("ck_param", dut_c.u_round.ck_parameter_in, ck_ref(run_n));
        run_n++;
      end else begin
        run_n = 0;
      end
      if (rd_pending) chk("rd_comb", rk_c, rd_exp);
      if (prev_valid) chk("rd_reg", rk_r, prev_exp);
      prev_valid = rd_pending;
      prev_exp   = rd_exp;
    end else begin
      prev_valid = 1'b0;
      run_n      = 0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (3) step();
    chk("rst_busy", busy_c, 1'b0);
    chk("rst_done", done_c, 1'b0);
    chk("rst_kv", kv_c, 1'b0);
    chk("rst_rk_c", rk_c, 32'h0);
    chk("rst_rk_r", rk_r, 32'h0);
    rst = 1'b0;
    step();

    // Standard vector, with an ignored re-start 10 cycles into RUN.
    issue_start(STD_MK);
    repeat (9) step();
    issue_start(128'hdeadbeef_00000000_cafef00d_12345678);
    wait_done();
    rd_const(5'd0, 1'b0, 32'hF12186F9);
    rd_const(5'd31, 1'b0, 32'h9124A012);
    rd_const(5'd0, 1'b1, 32'h9124A012);
    rd_const(5'd31, 1'b1, 32'hF12186F9);
    for (int i = 0; i < 6; i++) rd_m(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    rd_off();
    chk("kv_hold", kv_c, 1'b1);

    // Random keys with stray start pulses while busy.
    for (int n = 0; n < 3; n++) begin
      issue_start({$urandom, $urandom, $urandom, $urandom});
      repeat ($urandom_range(0, 20)) step();
      issue_start({$urandom, $urandom, $urandom, $urandom});
      wait_done();
      for (int i = 0; i < 5; i++) rd_m(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
      rd_off();
    end

    // Back-to-back: new start in the done_o cycle.
    issue_start(STD_MK);
    while (cyc < mdl_done) step();
    issue_start({$urandom, $urandom, $urandom, $urandom});
    chk("b2b_kv_drop", kv_c, 1'b0);
    chk("b2b_busy", busy_c, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) rd_m(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)));
    rd_off();

    // Async reset in the middle of RUN.
    rd_idx_i = 5'd3;
    dec_i    = 1'b0;
    issue_start(STD_MK);
    repeat (14) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy_c", busy_c, 1'b0);
    chk("arst_done_c", done_c, 1'b0);
    chk("arst_kv_c", kv_c, 1'b0);
    chk("arst_rk_c", rk_c, 32'h0);
    chk("arst_busy_r", busy_r, 1'b0);
    chk("arst_kv_r", kv_r, 1'b0);
    chk("arst_rk_r", rk_r, 32'h0);
    exp_q.delete();
    mdl_done = 0;
    mdl_mem  = '0;
    step();
    rst = 1'b0;
    step();
    rd_m(5'd7, 1'b1);
    rd_off();
    issue_start(128'h0);
    wait_done();
    rd_m(5'd0, 1'b0);
    rd_m(5'd31, 1'b0);
    rd_m(5'd4, 1'b1);
    rd_off();
    chk("zero_key_kv", kv_c, 1'b1);

    repeat (3) step();
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog");
  end

endmodule
